fp_mul_seq: RTL and testbench
=============================

// Module: fp_mul_seq
// PURPOSE
//  Multi-cycle sequencer for IEEE-754 single-precision multiply. Accepts one operand pair per
//  transaction on a valid/ready handshake. Drives the external 24x24 vedic mantissa multiplier
//  and samples its 48-bit product. Time-shares one add_24_bit instance for all exponent
//  arithmetic: add, bias subtract, normalise increment. Sits between the FP issue logic and
//  the result bus.
// PARAMETERS
//  MUL_LAT  2  clock cycles the external multiplier needs after mul_a/mul_b settle (1..15)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   sequencer idle, can accept
//  op_a       in   32  IEEE-754 single operand A
//  op_b       in   32  IEEE-754 single operand B
//  mul_a      out  24  {1'b1, frac_a} to vedic multiplier
//  mul_b      out  24  {1'b1, frac_b} to vedic multiplier
//  mul_p      in   48  multiplier product (combinational, valid MUL_LAT cycles after mul_a/b)
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  packed product
//  flags      out  3   {ovf, unf, zero}
// BEHAVIOUR
//  - Reset (async, rst_n low): state IDLE; in_ready=0, out_valid=0, result=0, flags=0,
//    mul_a=mul_b=0, wait_cnt=0. in_ready rises on the first clk edge after rst_n goes high.
//    Reset mid-transaction discards the transaction silently.
//  - States: IDLE -> EXP_ADD -> EXP_BIAS -> [WAIT] -> NORM -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready:
//    - latch sign = a[31]^b[31], ea, eb;
//    - drive mul_a/mul_b;
//    - in_ready=0; wait_cnt=0.
//    mul_a/b stay stable until NORM is left.
//  - wait_cnt increments every cycle after accept and saturates at 15.
//  - EXP_ADD: adder({16'b0,ea}, {16'b0,eb}) -> exp_r.
//  - EXP_BIAS: adder(exp_r, NEG_BIAS=24'hFFFF81) -> exp_r (two's complement; adder has no cin).
//    Next state is NORM if wait_cnt+1 >= MUL_LAT, else WAIT.
//  - WAIT: hold until wait_cnt >= MUL_LAT, then NORM.
//  - NORM: sample mul_p.
//    - If mul_p[47]: frac = mul_p[46:24]; adder(exp_r, 24'h000001) -> exp_r.
//    - Else: frac = mul_p[45:23]; exp_r unchanged.
//    - Rounding is truncation.
//  - DONE entry: compute result/flags, priority top-down:
//    - ea==0 or eb==0 (zero/denormal flushed): result={sign,31'b0}, zero=1.
//    - ea==255 or eb==255: result={sign,8'hFF,23'b0}, ovf=1.
//    - exp_r signed <= 0: result={sign,31'b0}, unf=1, zero=1.
//    - exp_r signed >= 255: result={sign,8'hFF,23'b0}, ovf=1.
//    - else: result={sign, exp_r[7:0], frac}.
//  - DONE: out_valid=1; result/flags held stable while out_ready=0.
//    - out_ready: out_valid drops next cycle; state IDLE; in_ready=1 the same edge.
//  - Latency: accept edge to out_valid = max(4, MUL_LAT+2) cycles.
//    Throughput: one transaction in flight; no overlap.
//  - in_valid during a transaction is ignored (in_ready=0). Operand changes after accept
//    have no effect.
// STRUCTURE
//  - Package fp_mul_pkg: state enum (IDLE, EXP_ADD, EXP_BIAS, WAIT, NORM, DONE),
//    EXP_BIAS=127, NEG_BIAS=24'hFFFF81, EXP_MAX=8'hFF, flag bit indices.
//  - Sub-module: one add_24_bit instance.
//    - Operand muxes are selected by state; the sum is registered into exp_r.
//  - Carry-out is unused.
//  - No second adder.
// TESTING
//  1. 0x40000000 x 0x40400000 (2.0 x 3.0) -> result 0x40C00000, flags 0, out_valid 4 cycles after accept.
//  2. 0x3FC00000 x 0x3FC00000 (1.5 x 1.5, mul_p[47]=1) -> 0x40100000; 0xC0000000 x 0x40400000 -> 0xC0C00000.
//  3. 0x00000000 x 0x40400000 -> 0x00000000, zero=1; 0x00800000 x 0x00800000 -> 0x00000000, unf=1, zero=1.
//  4. 0x7F000000 x 0x7F000000 -> 0x7F800000, ovf=1; 0x7F800000 x 0xBF800000 -> 0xFF800000, ovf=1.
//  5. MUL_LAT=6, test 1 operands; out_ready low 5 cycles -> out_valid at accept+8,
//     result stable through the stall, in_ready=1 the cycle after the out_ready handshake.
//  6. rst_n low during NORM -> out_valid=0, in_ready=0 immediately; after release,
//     a new transaction (test 1) completes correctly.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the single-precision multiply sequencer.
// Also holds the result packing rules used on DONE entry.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXP_ADD,
    EXP_BIAS,
    WAIT,
    NORM,
    DONE
  } state_t;

  localparam int unsigned EXP_BIAS_VAL = 127;
  localparam logic [23:0] NEG_BIAS     = 24'hFFFF81;
  localparam logic [7:0]  EXP_MAX      = 8'hFF;

  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
  } pack_t;

  // Special operands take priority over the computed exponent range checks.
  function automatic pack_t pack_product(input logic        sign,
                                         input logic [7:0]  ea,
                                         input logic [7:0]  eb,
                                         input logic [23:0] exp_r,
                                         input logic [22:0] frac);
    pack_t r;
    r.result = {sign, 31'b0};
    r.flags  = '0;
    if (ea == 8'h00 || eb == 8'h00) begin
      r.flags[FLAG_ZERO] = 1'b1;
    end else if (ea == EXP_MAX || eb == EXP_MAX) begin
      r.result          = {sign, EXP_MAX, 23'b0};
      r.flags[FLAG_OVF] = 1'b1;
    end else if ($signed(exp_r) <= 24'sd0) begin
      r.flags[FLAG_UNF]  = 1'b1;
      r.flags[FLAG_ZERO] = 1'b1;
    end else if ($signed(exp_r) >= 24'sd255) begin
      r.result          = {sign, EXP_MAX, 23'b0};
      r.flags[FLAG_OVF] = 1'b1;
    end else begin
      r.result = {sign, exp_r[7:0], frac};
    end
    return r;
  endfunction

endpackage

// File: rtl/add_24_bit.sv
// Plain 24-bit adder with carry-out; shared by all exponent arithmetic.
module add_24_bit (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [23:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiply sequencer driving an external
// 24x24 mantissa multiplier and one time-shared exponent adder.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  input  logic [47:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam logic [4:0] LAT5 = 5'(MUL_LAT);

  state_t      state, next_state;
  logic        sign_r;
  logic [7:0]  ea_r, eb_r;
  logic [3:0]  wait_cnt;
  logic [23:0] exp_r;
  logic [22:0] frac_r;

  logic [23:0] add_a, add_b, add_sum;
  logic        add_cout;
  logic        exp_load;
  logic        accept;
  logic        lat_met;
  pack_t       packed_res;
  logic        sig_unused;

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign packed_res = pack_product(sign_r, ea_r, eb_r, exp_r, frac_r);
  assign sig_unused = ^{add_cout, mul_p[22:0]};

  // Both EXP_BIAS and WAIT look at the count's next value, so NORM is entered
  // on the same edge that wait_cnt reaches MUL_LAT.
  assign lat_met = ({1'b0, wait_cnt} + 5'd1) >= LAT5;

  add_24_bit u_exp_add (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    next_state = state;
    add_a      = '0;
    add_b      = '0;
    exp_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) next_state = EXP_ADD;
      end
      EXP_ADD: begin
        add_a      = {16'b0, ea_r};
        add_b      = {16'b0, eb_r};
        exp_load   = 1'b1;
        next_state = EXP_BIAS;
      end
      EXP_BIAS: begin
        add_a      = exp_r;
        add_b      = NEG_BIAS;
        exp_load   = 1'b1;
        next_state = lat_met ? NORM : WAIT;
      end
      WAIT: begin
        if (lat_met) next_state = NORM;
      end
      NORM: begin
        // Adding the normalise bit leaves exp_r unchanged when mul_p[47] is clear.
        add_a      = exp_r;
        add_b      = {23'b0, mul_p[47]};
        exp_load   = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      sign_r    <= 1'b0;
      ea_r      <= '0;
      eb_r      <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      wait_cnt  <= '0;
      exp_r     <= '0;
      frac_r    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == IDLE);

      if (accept) begin
        sign_r   <= op_a[31] ^ op_b[31];
        ea_r     <= op_a[30:23];
        eb_r     <= op_b[30:23];
        mul_a    <= {1'b1, op_a[22:0]};
        mul_b    <= {1'b1, op_b[22:0]};
        wait_cnt <= '0;
      end else if (state != IDLE && wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (exp_load) exp_r <= add_sum;

      if (state == NORM) begin
        frac_r <= mul_p[47] ? mul_p[46:24] : mul_p[45:23];
      end

      if (state == DONE) begin
        if (!out_valid) begin
          result    <= packed_res.result;
          flags     <= packed_res.flags;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: two instances (MUL_LAT 2 and 6), a latency-accurate
// multiplier model, and a value-level IEEE-754 reference for every result.
`timescale 1ns/1ps
module tb_fp_mul_seq;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [31:0] op_a      [N];
  logic [31:0] op_b      [N];
  logic [23:0] mul_a     [N];
  logic [23:0] mul_b     [N];
  logic [47:0] mul_p     [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [31:0] result    [N];
  logic [2:0]  flags     [N];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit          pending [N];
  bit          seen    [N];
  bit          hs_next [N];
  logic [34:0] exp_rf  [N];
  int          acc_cyc [N];
  int          acc_cnt [N];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 6;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : 6;

    fp_mul_seq #(.MUL_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op_a      (op_a[g]),
      .op_b      (op_b[g]),
      .mul_a     (mul_a[g]),
      .mul_b     (mul_b[g]),
      .mul_p     (mul_p[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .flags     (flags[g])
    );

    // Multiplier output is garbage until the operands have been stable long enough.
    int unsigned age = 0;
    logic [47:0] last_ab = '0;
    always @(negedge clk) begin
      if ({mul_a[g], mul_b[g]} != last_ab) begin
        last_ab = {mul_a[g], mul_b[g]};
        age     = 0;
      end else if (age < 1000) begin
        age++;
      end
    end
    assign mul_p[g] = (age + 1 >= LAT) ? (48'(mul_a[g]) * 48'(mul_b[g])) : 48'hA5A5_5A5A_A5A5;
  end

  // Reference: {result, flags} from real-number rules, truncating rounding.
  function automatic logic [34:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint unsigned ma, mb, p;
    logic [22:0] f;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0)     return {s, 31'b0, 3'b001};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'b0, 3'b100};
    ma = 64'({1'b1, a[22:0]});
    mb = 64'({1'b1, b[22:0]});
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h8000_0000_0000) begin
      e = e + 1;
      f = 23'(p >> 24);
    end else begin
      f = 23'(p >> 23);
    end
    if (e <= 0)   return {s, 31'b0, 3'b011};
    if (e >= 255) return {s, 8'hFF, 23'b0, 3'b100};
    return {s, 8'(e), f, 3'b000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst_n && in_valid[i] && in_ready[i]) begin
        pending[i] = 1'b1;
        seen[i]    = 1'b0;
        exp_rf[i]  = fp_ref(op_a[i], op_b[i]);
        acc_cyc[i] = cyc;
        acc_cnt[i] = acc_cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        pending[i] = 1'b0;
        seen[i]    = 1'b0;
        hs_next[i] = 1'b0;
      end else if (hs_next[i]) begin
        chk("in_ready_after_handshake", 64'(in_ready[i]), 64'd1);
        chk("out_valid_drop", 64'(out_valid[i]), 64'd0);
        hs_next[i] = 1'b0;
      end else if (out_valid[i]) begin
        if (!pending[i]) begin
          chk("spurious_out_valid", 64'(out_valid[i]), 64'd0);
        end else begin
          if (!seen[i]) begin
            int exp_lat;
            exp_lat = lat_of(i) + 2;
            if (exp_lat < 4) exp_lat = 4;
            chk("latency", 64'(cyc - acc_cyc[i]), 64'(exp_lat));
            seen[i] = 1'b1;
          end
          chk("result_flags", 64'({result[i], flags[i]}), 64'(exp_rf[i]));
          if (out_ready[i]) begin
            pending[i] = 1'b0;
            hs_next[i] = 1'b1;
          end
        end
      end else if (pending[i] && (cyc - acc_cyc[i]) > 40) begin
        chk("out_valid_timeout", 64'(out_valid[i]), 64'd1);
        pending[i] = 1'b0;
      end
    end
  end

  task automatic wait_accept(input int i, input int n0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (acc_cnt[i] != n0) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input int i, input logic [31:0] a, input logic [31:0] b,
                         input int stall, output logic [34:0] got);
    int n0;
    int v;
    bit ok;
    got = '1;
    @(posedge clk); #1;
    op_a[i] = a;
    op_b[i] = b;
    in_valid[i]  = 1'b1;
    out_ready[i] = 1'b0;
    n0 = acc_cnt[i];
    wait_accept(i, n0, ok);
    in_valid[i] = 1'b0;
    op_a[i] = $urandom;
    op_b[i] = $urandom;
    if (!ok) begin
      chk("accept_timeout", 64'(acc_cnt[i]), 64'(n0 + 1));
      return;
    end
    ok = 1'b0;
    v  = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      if (out_valid[i]) begin
        if (v == stall) begin
          got = {result[i], flags[i]};
          out_ready[i] = 1'b1;
          @(posedge clk); #1;
          out_ready[i] = 1'b0;
          ok = 1'b1;
        end else begin
          v++;
        end
      end
    end
    if (!ok) chk("done_timeout", 64'(out_valid[i]), 64'd1);
  endtask

  localparam int NV = 15;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [34:0] vr [NV];

  initial begin
    logic [34:0] got;
    int n0;
    bit ok;

    va = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h00000000, 32'h00800000,
           32'h7F000000, 32'h7F800000, 32'h7F000000, 32'h00800000, 32'h00800000,
           32'h7F7FFFFF, 32'hBFC00000, 32'h80000000, 32'h3F800000, 32'h3F800001};
    vb = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h40400000, 32'h00800000,
           32'h7F000000, 32'hBF800000, 32'h3F800000, 32'h3F000000, 32'h3F800000,
           32'h3FFFFFFF, 32'hBFC00000, 32'h40000000, 32'h3F800000, 32'h3F800001};
    vr = '{{32'h40C00000, 3'b000}, {32'h40100000, 3'b000}, {32'hC0C00000, 3'b000},
           {32'h00000000, 3'b001}, {32'h00000000, 3'b011}, {32'h7F800000, 3'b100},
           {32'hFF800000, 3'b100}, {32'h7F000000, 3'b000}, {32'h00000000, 3'b011},
           {32'h00800000, 3'b000}, {32'h7F800000, 3'b100}, {32'h40100000, 3'b000},
           {32'h80000000, 3'b001}, {32'h3F800000, 3'b000}, {32'h3F800002, 3'b000}};

    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      op_a[i]      = '0;
      op_b[i]      = '0;
      acc_cnt[i]   = 0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("reset_in_ready", 64'(in_ready[i]), 64'd0);
      chk("reset_out_valid", 64'(out_valid[i]), 64'd0);
      chk("reset_result_flags", 64'({result[i], flags[i]}), 64'd0);
      chk("reset_mul_ab", 64'({mul_a[i], mul_b[i]}), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk("in_ready_after_reset", 64'(in_ready[i]), 64'd1);

    for (int v = 0; v < NV; v++) begin
      chk($sformatf("model_vec%0d", v), 64'(fp_ref(va[v], vb[v])), 64'(vr[v]));
      run_txn(0, va[v], vb[v], 0, got);
      chk($sformatf("dut_lat2_vec%0d", v), 64'(got), 64'(vr[v]));
    end

    run_txn(1, 32'h40000000, 32'h40400000, 5, got);
    chk("dut_lat6_stall", 64'(got), {29'd0, 32'h40C00000, 3'b000});
    for (int v = 0; v < 4; v++) begin
      run_txn(1, va[v + 4], vb[v + 4], v, got);
      chk($sformatf("dut_lat6_vec%0d", v + 4), 64'(got), 64'(vr[v + 4]));
    end

    // Reset while instance 0 sits in NORM
    @(posedge clk); #1;
    op_a[0] = 32'h40000000;
    op_b[0] = 32'h40400000;
    in_valid[0] = 1'b1;
    n0 = acc_cnt[0];
    wait_accept(0, n0, ok);
    in_valid[0] = 1'b0;
    if (!ok) chk("midreset_accept", 64'(acc_cnt[0]), 64'(n0 + 1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midreset_in_ready", 64'(in_ready[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midreset_no_result", 64'(out_valid[0]), 64'd0);
    run_txn(0, 32'h40000000, 32'h40400000, 0, got);
    chk("after_midreset", 64'(got), {29'd0, 32'h40C00000, 3'b000});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
